// File: rtl/state_sequencer.sv
// state_sequencer: steps through a loaded table of {dwell, config} words, one entry per dwell period
module state_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CFG_W   = 16,
    parameter int DWELL_W = 16,
    parameter int ADDR_W  = 5
) (
    input  logic              mainclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              enable,
    input  logic              loop,
    output logic [CFG_W-1:0]  cfg,
    output logic [ADDR_W-1:0] state_index,
    output logic              step_pulse,
    output logic              done,
    output logic              seq_error,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]    FULL      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0]  IDX_ONE   = 1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DWELL_W-1:0]  dwell_cnt, dwell_n;
    logic [ADDR_W-1:0]   idx_n, entry;
    logic [ADDR_W:0]     count_n;
    logic [CFG_W-1:0]    cfg_n;
    logic [DATA_W-1:0]   word;
    logic                step_n, we, enter;

    // next state, table write decision and next-entry load; outputs default to zero outside RUN
    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = '0;
        dwell_n = '0;
        cfg_n   = '0;
        step_n  = 1'b0;
        we      = 1'b0;
        enter   = 1'b0;
        entry   = '0;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_n = '0;
                end else if (wr_en) begin
                    if (count == FULL) begin
                        state_n = ERROR;
                    end else begin
                        we      = 1'b1;
                        count_n = count + CNT_ONE;
                    end
                end
                if (enable && state_n == IDLE) begin
                    if (count_n == '0) state_n = ERROR;
                    else enter = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (dwell_cnt == DWELL_ONE) begin
                    if ({1'b0, state_index} + CNT_ONE == count) begin
                        if (loop) enter = 1'b1;
                        else state_n = DONE;
                    end else begin
                        enter = 1'b1;
                        entry = state_index + IDX_ONE;
                    end
                end else begin
                    dwell_n = dwell_cnt - DWELL_ONE;
                    idx_n   = state_index;
                    cfg_n   = cfg;
                end
            end
            DONE, ERROR: state_n = enable ? state : IDLE;
            default: state_n = IDLE;
        endcase
        // a write accepted in the enabling cycle into an empty table is entry 0 itself
        word = (we && count == '0) ? wr_data : mem[entry];
        if (enter) begin
            if (word[DATA_W-1 -: DWELL_W] == '0) begin
                state_n = ERROR;
            end else begin
                state_n = RUN;
                idx_n   = entry;
                dwell_n = word[DATA_W-1 -: DWELL_W];
                cfg_n   = word[CFG_W-1:0];
                step_n  = (state == RUN);
            end
        end
    end

    // state register and registered outputs
    always_ff @(posedge mainclk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dwell_cnt   <= '0;
            state_index <= '0;
            cfg         <= '0;
            step_pulse  <= 1'b0;
            done        <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            dwell_cnt   <= dwell_n;
            state_index <= idx_n;
            cfg         <= cfg_n;
            step_pulse  <= step_n;
            done        <= (state_n == DONE);
            seq_error   <= (state_n == ERROR);
        end
    end

    // table storage, deliberately not reset
    always_ff @(posedge mainclk) begin
        if (we && !reset) mem[count[ADDR_W-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer: directed checks of load, run, loop, error and reset behaviour
module tb_state_sequencer;
    logic        clk = 1'b0;
    logic        reset, wr_en, clear, enable, loop;
    logic [31:0] wr_data;
    logic [15:0] cfg;
    logic [4:0]  state_index;
    logic        step_pulse, done, seq_error;
    logic [5:0]  count;
    int          checks = 0;
    int          errors = 0;

    state_sequencer dut (
        .mainclk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .enable(enable), .loop(loop), .cfg(cfg), .state_index(state_index),
        .step_pulse(step_pulse), .done(done), .seq_error(seq_error), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] dw, input logic [15:0] c);
        wr_en = 1'b1;
        wr_data = {dw, c};
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_t1();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wr(16'd2, 16'h000A);
        wr(16'd3, 16'h000B);
        wr(16'd1, 16'h000C);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({cfg, state_index, step_pulse, done, seq_error, count} !== 30'd0) begin
            errors++;
            $display("FAIL reset outs=%h exp=0", {cfg, state_index, step_pulse, done, seq_error, count});
        end
    endtask

    task automatic test_single_pass();
        logic [15:0] ec [7] = '{16'h0A, 16'h0A, 16'h0B, 16'h0B, 16'h0B, 16'h0C, 16'h00};
        logic [4:0]  ei [7] = '{0, 0, 1, 1, 1, 2, 0};
        logic        es [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic        ed [7] = '{0, 0, 0, 0, 0, 0, 1};
        load_t1();
        checks++;
        if (count !== 6'd3) begin
            errors++;
            $display("FAIL t1_count count=%0d exp=3", count);
        end
        loop = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({cfg, state_index, step_pulse, done} !== {ec[i], ei[i], es[i], ed[i]}) begin
                errors++;
                $display("FAIL t1_seq[%0d] cfg=%h idx=%0d step=%b done=%b exp cfg=%h idx=%0d step=%b done=%b",
                         i, cfg, state_index, step_pulse, done, ec[i], ei[i], es[i], ed[i]);
            end
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({done, cfg, count} !== {1'b0, 16'h0, 6'd3}) begin
            errors++;
            $display("FAIL t1_idle done=%b cfg=%h count=%0d exp 0/0/3", done, cfg, count);
        end
    endtask

    task automatic test_loop();
        logic [15:0] pc [6] = '{16'h0A, 16'h0A, 16'h0B, 16'h0B, 16'h0B, 16'h0C};
        logic [4:0]  pi [6] = '{0, 0, 1, 1, 1, 2};
        logic        ps [6] = '{1, 0, 1, 0, 0, 1};
        logic        es;
        loop = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 4) begin
                wr_en = 1'b1;
                wr_data = 32'h0001_00FF;
            end
            tick();
            wr_en = 1'b0;
            es = (i == 0) ? 1'b0 : ps[i % 6];
            checks++;
            if ({cfg, state_index, step_pulse, done} !== {pc[i % 6], pi[i % 6], es, 1'b0}) begin
                errors++;
                $display("FAIL t2_loop[%0d] cfg=%h idx=%0d step=%b done=%b exp cfg=%h idx=%0d step=%b",
                         i, cfg, state_index, step_pulse, done, pc[i % 6], pi[i % 6], es);
            end
        end
        checks++;
        if (count !== 6'd3) begin
            errors++;
            $display("FAIL t2_run_write count=%0d exp=3", count);
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({cfg, state_index, count} !== {16'h0, 5'd0, 6'd3}) begin
            errors++;
            $display("FAIL t6_disable cfg=%h idx=%0d count=%0d exp 0/0/3", cfg, state_index, count);
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({cfg, state_index, step_pulse} !== {16'h0A, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL t6_restart cfg=%h idx=%0d step=%b exp 0a/0/0", cfg, state_index, step_pulse);
        end
        tick();
        tick();
        checks++;
        if ({cfg, state_index, step_pulse} !== {16'h0B, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL t6_restart2 cfg=%h idx=%0d step=%b exp 0b/1/1", cfg, state_index, step_pulse);
        end
        enable = 1'b0;
        loop = 1'b0;
        tick();
    endtask

    task automatic test_empty_error();
        clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'h0001_0011;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (count !== 6'd0) begin
            errors++;
            $display("FAIL t3_clear_beats_write count=%0d exp=0", count);
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({seq_error, cfg} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL t3_empty err=%b cfg=%h exp 1/0", seq_error, cfg);
        end
        tick();
        checks++;
        if (seq_error !== 1'b1) begin
            errors++;
            $display("FAIL t3_error_held err=%b exp=1", seq_error);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (seq_error !== 1'b0) begin
            errors++;
            $display("FAIL t3_leave err=%b exp=0", seq_error);
        end
        wr(16'd1, 16'h0022);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        tick();
        checks++;
        if ({seq_error, count} !== {1'b1, 6'd0}) begin
            errors++;
            $display("FAIL t3_clear_enable err=%b count=%0d exp 1/0", seq_error, count);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 32; i++) wr(16'd1, 16'(i));
        checks++;
        if ({count, seq_error} !== {6'd32, 1'b0}) begin
            errors++;
            $display("FAIL t4_full count=%0d err=%b exp 32/0", count, seq_error);
        end
        wr(16'd1, 16'h00EE);
        checks++;
        if ({count, seq_error} !== {6'd32, 1'b1}) begin
            errors++;
            $display("FAIL t4_overflow count=%0d err=%b exp 32/1", count, seq_error);
        end
        tick();
    endtask

    task automatic test_zero_dwell();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wr(16'd2, 16'h0001);
        wr(16'd0, 16'h0002);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cfg, seq_error} !== {16'h0001, 1'b0}) begin
                errors++;
                $display("FAIL t5_first[%0d] cfg=%h err=%b exp 0001/0", i, cfg, seq_error);
            end
        end
        tick();
        checks++;
        if ({cfg, seq_error} !== {16'h0, 1'b1}) begin
            errors++;
            $display("FAIL t5_zero cfg=%h err=%b exp 0/1", cfg, seq_error);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wr_en = 1'b1;
        wr_data = 32'h0001_0055;
        enable = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if ({cfg, count, step_pulse} !== {16'h0055, 6'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_enable cfg=%h count=%0d step=%b exp 0055/1/0", cfg, count, step_pulse);
        end
        tick();
        checks++;
        if ({done, cfg} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL b2b_done done=%b cfg=%h exp 1/0", done, cfg);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_dwell();
        load_t1();
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({cfg, state_index, step_pulse, done, seq_error, count} !== 30'd0) begin
            errors++;
            $display("FAIL t6_reset outs=%h exp=0", {cfg, state_index, step_pulse, done, seq_error, count});
        end
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        clear = 1'b0;
        enable = 1'b0;
        loop = 1'b0;
        test_reset();
        test_single_pass();
        test_loop();
        test_empty_error();
        test_overflow();
        test_zero_dwell();
        test_back_to_back();
        test_reset_mid_dwell();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
